// File: rtl/uart_pixel_pkg.sv
// Shared types and defaults for the UART byte-to-RGB pixel packer.
package uart_pixel_pkg;

    typedef enum logic [2:0] {
        WAIT_H0,
        WAIT_H1,
        GET_R,
        GET_G,
        GET_B
    } pix_state_t;

    localparam logic [7:0]  HDR0_DEF        = 8'h55;
    localparam logic [7:0]  HDR1_DEF        = 8'hAA;
    localparam int unsigned PIC_PIXELS_DEF  = 40000;
    localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000;

    // Counter only has to reach TIMEOUT_CYC-1.
    function automatic int unsigned timer_width(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage

// File: rtl/byte_gap_timer.sv
// Inter-byte gap timer: counts idle cycles and flags expiry at TIMEOUT_CYC-1.
module byte_gap_timer
    import uart_pixel_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int unsigned    W    = timer_width(TIMEOUT_CYC);
    localparam logic [W-1:0]   LAST = W'(TIMEOUT_CYC - 1);

    logic [W-1:0] cnt;

    // A clear in the expiry cycle wins, so a byte arriving exactly then is not lost.
    assign expire = en && !clr && (cnt == LAST);

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            cnt <= '0;
        end else if (clr || expire) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + W'(1);
        end
    end

endmodule

// File: rtl/uart_pixel_pack.sv
// Packs received UART bytes into 24-bit {R,G,B} pixels framed by a 2-byte header.
module uart_pixel_pack
    import uart_pixel_pkg::*;
#(
    parameter int unsigned PIC_PIXELS  = PIC_PIXELS_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    parameter logic [7:0]  HDR0        = HDR0_DEF,
    parameter logic [7:0]  HDR1        = HDR1_DEF
) (
    input  logic        sys_clk,
    input  logic        sys_rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_flag,
    output logic [23:0] pi_data,
    output logic        pi_flag,
    output logic [15:0] pix_cnt,
    output logic        frame_start,
    output logic        frame_done,
    output logic        sync_err
);

    localparam logic [15:0] LAST_PIX = 16'(PIC_PIXELS - 1);

    pix_state_t  state, state_nxt;
    logic [7:0]  r_reg, g_reg;
    logic        timeout;
    logic        emit, last, start;

    byte_gap_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_gap_timer (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .clr      (rx_flag || (state == WAIT_H0)),
        .en       (state != WAIT_H0),
        .expire   (timeout)
    );

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state <= WAIT_H0;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        emit      = 1'b0;
        last      = 1'b0;
        start     = 1'b0;
        if (rx_flag) begin
            case (state)
                WAIT_H0: if (rx_data == HDR0) state_nxt = WAIT_H1;
                WAIT_H1: begin
                    if (rx_data == HDR1) begin
                        state_nxt = GET_R;
                        start     = 1'b1;
                    end else if (rx_data != HDR0) begin
                        state_nxt = WAIT_H0;
                    end
                end
                GET_R:   state_nxt = GET_G;
                GET_G:   state_nxt = GET_B;
                GET_B: begin
                    emit = 1'b1;
                    if (pix_cnt == LAST_PIX) begin
                        last      = 1'b1;
                        state_nxt = WAIT_H0;
                    end else begin
                        state_nxt = GET_R;
                    end
                end
                default: state_nxt = WAIT_H0;
            endcase
        end else if (timeout) begin
            state_nxt = WAIT_H0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            r_reg       <= '0;
            g_reg       <= '0;
            pi_data     <= '0;
            pi_flag     <= 1'b0;
            pix_cnt     <= '0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            pi_flag     <= emit;
            frame_start <= start;
            frame_done  <= last;
            sync_err    <= timeout;
            if (rx_flag && state == GET_R) r_reg <= rx_data;
            if (rx_flag && state == GET_G) g_reg <= rx_data;
            if (emit) pi_data <= {r_reg, g_reg, rx_data};
            if (start || last || timeout) begin
                pix_cnt <= '0;
            end else if (emit) begin
                pix_cnt <= pix_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_uart_pixel_pack.sv
// Directed bench for uart_pixel_pack with a 4-pixel frame and 100-cycle gap timeout.
module tb_uart_pixel_pack;

    logic        sys_clk;
    logic        sys_rst_n;
    logic [7:0]  rx_data;
    logic        rx_flag;
    logic [23:0] pi_data;
    logic        pi_flag;
    logic [15:0] pix_cnt;
    logic        frame_start;
    logic        frame_done;
    logic        sync_err;

    int n_checks = 0;
    int n_errors = 0;
    int n_pix    = 0;
    int n_serr   = 0;

    uart_pixel_pack #(
        .PIC_PIXELS (4),
        .TIMEOUT_CYC(100),
        .HDR0       (8'h55),
        .HDR1       (8'hAA)
    ) dut (
        .sys_clk    (sys_clk),
        .sys_rst_n  (sys_rst_n),
        .rx_data    (rx_data),
        .rx_flag    (rx_flag),
        .pi_data    (pi_data),
        .pi_flag    (pi_flag),
        .pix_cnt    (pix_cnt),
        .frame_start(frame_start),
        .frame_done (frame_done),
        .sync_err   (sync_err)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    always @(negedge sys_clk) begin
        if (pi_flag)  n_pix++;
        if (sync_err) n_serr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the next negedge, so consecutive calls are back-to-back.
    task automatic put(input logic [7:0] b);
        rx_data = b;
        rx_flag = 1'b1;
        @(negedge sys_clk);
        rx_flag = 1'b0;
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge sys_clk);
    endtask

    initial begin
        int pix0;
        int serr0;
        int waited;
        logic [7:0] r, g, b;

        sys_rst_n = 1'b0;
        rx_data   = '0;
        rx_flag   = 1'b0;
        idle(3);
        check("rst_pi_data", 32'(pi_data), 32'h0);
        check("rst_pi_flag", 32'(pi_flag), 32'h0);
        check("rst_pix_cnt", 32'(pix_cnt), 32'h0);
        check("rst_frame_start", 32'(frame_start), 32'h0);
        check("rst_frame_done", 32'(frame_done), 32'h0);
        check("rst_sync_err", 32'(sync_err), 32'h0);
        sys_rst_n = 1'b1;
        idle(2);

        // Spaced bytes 55 AA 12 34 56
        put(8'h55); idle(9);
        put(8'hAA);
        check("t1_frame_start", 32'(frame_start), 32'h1);
        check("t1_pix_cnt_hdr", 32'(pix_cnt), 32'h0);
        idle(1);
        check("t1_frame_start_1cyc", 32'(frame_start), 32'h0);
        idle(8);
        put(8'h12); idle(9);
        put(8'h34);
        check("t1_no_pi_flag_g", 32'(pi_flag), 32'h0);
        idle(9);
        put(8'h56);
        check("t1_pi_flag", 32'(pi_flag), 32'h1);
        check("t1_pi_data", 32'(pi_data), 32'h123456);
        check("t1_pix_cnt", 32'(pix_cnt), 32'h1);
        idle(1);
        check("t1_pi_flag_1cyc", 32'(pi_flag), 32'h0);
        check("t1_pi_data_hold", 32'(pi_data), 32'h123456);

        // Finish that frame (pixels 2..4)
        put(8'hA1); put(8'hA2); put(8'hA3);
        put(8'hB1); put(8'hB2); put(8'hB3);
        check("t1_pix_cnt3", 32'(pix_cnt), 32'h3);
        check("t1_no_done_early", 32'(frame_done), 32'h0);
        put(8'hC1); put(8'hC2); put(8'hC3);
        check("t1_frame_done", 32'(frame_done), 32'h1);
        check("t1_last_pi_flag", 32'(pi_flag), 32'h1);
        check("t1_last_data", 32'(pi_data), 32'hC1C2C3);
        check("t1_pix_cnt_wrap", 32'(pix_cnt), 32'h0);
        idle(2);

        // Full frame, 14 back-to-back bytes
        pix0 = n_pix;
        put(8'h55); put(8'hAA);
        for (int p = 0; p < 4; p++) begin
            r = 8'h10 + 8'(p);
            g = 8'h20 + 8'(p);
            b = 8'h30 + 8'(p);
            put(r); put(g); put(b);
            check("ff_pi_flag", 32'(pi_flag), 32'h1);
            check("ff_pi_data", 32'(pi_data), {8'h00, r, g, b});
            check("ff_pix_cnt", 32'(pix_cnt), (p == 3) ? 32'h0 : 32'(p + 1));
            check("ff_frame_done", 32'(frame_done), (p == 3) ? 32'h1 : 32'h0);
        end
        put(8'h77); put(8'h88); put(8'h99);
        idle(1);
        check("ff_pixel_count", 32'(n_pix - pix0), 32'h4);
        check("ff_post_frame_pix_cnt", 32'(pix_cnt), 32'h0);

        // Repeated HDR0 before HDR1
        put(8'h55); put(8'h55); put(8'hAA);
        check("h55_frame_start", 32'(frame_start), 32'h1);

        // Timeout after R,G
        pix0  = n_pix;
        serr0 = n_serr;
        put(8'h11); put(8'h22);
        waited = 0;
        for (int i = 1; i <= 150; i++) begin
            if (sync_err) begin
                waited = i - 1;
                break;
            end
            @(negedge sys_clk);
        end
        check("to_sync_err_latency", 32'(waited), 32'd100);
        check("to_sync_err", 32'(sync_err), 32'h1);
        check("to_pix_cnt", 32'(pix_cnt), 32'h0);
        idle(1);
        check("to_sync_err_1cyc", 32'(sync_err), 32'h0);
        check("to_no_pi_flag", 32'(n_pix - pix0), 32'h0);
        check("to_one_pulse", 32'(n_serr - serr0), 32'h1);
        put(8'h55); put(8'hAA); put(8'h01); put(8'h02); put(8'h03);
        check("to_resync_data", 32'(pi_data), 32'h010203);
        check("to_resync_pix_cnt", 32'(pix_cnt), 32'h1);

        // Let the open frame time out, then a broken header
        idle(110);
        pix0 = n_pix;
        put(8'h55); put(8'h13); put(8'hAA);
        check("bad_hdr_no_start", 32'(frame_start), 32'h0);
        put(8'h01); put(8'h02); put(8'h03);
        idle(1);
        check("bad_hdr_no_pixel", 32'(n_pix - pix0), 32'h0);

        // Byte arriving exactly on the expiry cycle
        put(8'h55); put(8'hAA); put(8'h44);
        serr0 = n_serr;
        idle(99);
        put(8'h55);
        check("exp_no_sync_err", 32'(sync_err), 32'h0);
        put(8'h66);
        check("exp_pi_flag", 32'(pi_flag), 32'h1);
        check("exp_pi_data", 32'(pi_data), 32'h445566);
        idle(1);
        check("exp_no_serr_pulse", 32'(n_serr - serr0), 32'h0);

        // Reset mid-pixel
        put(8'hDE); put(8'hAD);
        sys_rst_n = 1'b0;
        #1;
        check("mr_pi_data", 32'(pi_data), 32'h0);
        check("mr_pix_cnt", 32'(pix_cnt), 32'h0);
        check("mr_pi_flag", 32'(pi_flag), 32'h0);
        check("mr_sync_err", 32'(sync_err), 32'h0);
        @(negedge sys_clk);
        sys_rst_n = 1'b1;
        idle(1);
        pix0 = n_pix;
        put(8'h04); put(8'h05); put(8'h06);
        idle(1);
        check("mr_no_pixel", 32'(n_pix - pix0), 32'h0);
        put(8'h55); put(8'hAA); put(8'h07); put(8'h08); put(8'h09);
        check("mr_after_hdr_data", 32'(pi_data), 32'h070809);
        check("mr_after_hdr_cnt", 32'(pix_cnt), 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/uart_pixel_pack.md
# uart_pixel_pack

- Packs the byte stream from the RS-232 receiver (8-bit data + one-cycle valid strobe, sys_clk domain) into 24-bit RGB pixels.
- Emits each pixel as `pi_data`/`pi_flag`, the write-side inputs of the picture-buffer/VGA stage directly downstream.
- Frames start with a 2-byte header. A pixel counter marks frame completion. A byte-gap timeout resynchronises after line errors or dropped bytes.

## Interface
Parameters:
- PIC_PIXELS, 40000, pixels per frame (200x200).
- TIMEOUT_CYC, 1_000_000, max sys_clk cycles between bytes inside a frame (20 ms at 50 MHz).
- HDR0, 8'h55, first header byte.
- HDR1, 8'hAA, second header byte.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset; asynchronous, active-low.
- rx_data  in  8  received byte; valid only while rx_flag=1.
- rx_flag  in  1  one-cycle strobe per received byte.
- pi_data  out  24  packed pixel {R,G,B}.
- pi_flag  out  1  one-cycle pulse; pi_data valid.
- pix_cnt  out  16  pixels emitted in the current frame, 0..PIC_PIXELS-1.
- frame_start  out  1  one-cycle pulse when the header is accepted.
- frame_done  out  1  one-cycle pulse together with the pi_flag of the last pixel.
- sync_err  out  1  one-cycle pulse when a timeout aborts a frame.

## Operation
State machine states: WAIT_H0, WAIT_H1, GET_R, GET_G, GET_B. Transitions are taken only on rx_flag=1 unless noted.
- WAIT_H0:
  - byte==HDR0 -> WAIT_H1.
  - Other bytes are ignored. No timeout in this state.
- WAIT_H1:
  - byte==HDR1 -> GET_R; pulse frame_start; pix_cnt<=0.
  - byte==HDR0 -> stay in WAIT_H1.
  - Any other byte -> WAIT_H0.
- GET_R: latch byte into r_reg -> GET_G.
- GET_G: latch byte into g_reg -> GET_B.
- GET_B:
  - pi_data <= {r_reg, g_reg, byte}; pulse pi_flag.
  - If pix_cnt==PIC_PIXELS-1: pulse frame_done, pix_cnt<=0, -> WAIT_H0.
  - Otherwise: pix_cnt<=pix_cnt+1 -> GET_R.
- Header bytes inside pixel data have no special meaning; all bytes in GET_* states are treated as data.
- Gap timer:
  - Clears on every rx_flag and in WAIT_H0.
  - Increments every cycle in any other state.
  - On reaching TIMEOUT_CYC-1 with rx_flag=0: -> WAIT_H0, pulse sync_err, pix_cnt<=0, partial R/G discarded, no pi_flag.
- rx_flag coinciding with timer expiry: the byte is processed normally, the timer clears, and there is no sync_err.
- pix_cnt is 16 bits and never exceeds PIC_PIXELS-1; it wraps to 0 only via frame_done, a header or a timeout.

## Timing
- Reset values of all outputs are 0: pi_data=0, pi_flag=0, pix_cnt=0, frame_start=0, frame_done=0, sync_err=0. State=WAIT_H0, timer=0, r_reg=g_reg=0.
- All outputs are registered.
- pi_flag, frame_start, frame_done and sync_err assert exactly 1 cycle after the triggering rx_flag cycle or timer-expiry cycle, for exactly 1 cycle.
- pi_data holds its value until the next pi_flag.
- pix_cnt updates in the same cycle as pi_flag.
- Minimum byte spacing is 1 cycle; back-to-back rx_flag is fully supported. Throughput is 1 pixel per 3 bytes with no stalls.
- Reset asserted mid-frame clears everything immediately. After release the block waits for a fresh header; no output pulses are generated by reset.

## Structure
- Package `uart_pixel_pkg`:
  - state enum / localparams for WAIT_H0..GET_B.
  - default HDR0/HDR1.
  - PIC_PIXELS default.
  - timer width, computed with clog2 of TIMEOUT_CYC.
- Sub-module `byte_gap_timer`: clear/enable inputs, expire output, parameter TIMEOUT_CYC. The top level holds the FSM, pixel registers and counters.

## Test plan
- Reset release, then bytes 55 AA 12 34 56 with rx_flag spaced 10 cycles -> frame_start 1 cycle after AA; pi_flag 1 cycle after 56 with pi_data=24'h123456; pix_cnt=1.
- Bytes 55 55 AA -> frame accepted. Bytes 55 13 AA -> no frame_start; state returns to WAIT_H0.
- Full frame at PIC_PIXELS=4, 14 back-to-back bytes -> 4 pi_flag pulses; frame_done with the 4th; pix_cnt back to 0; the next data byte is ignored until a new header arrives.
- After header + R + G, stop sending for TIMEOUT_CYC=100 cycles -> sync_err at cycle 100; no pi_flag. A following 55 AA 01 02 03 yields pi_data=24'h010203.
- rx_flag on the exact timer-expiry cycle -> byte accepted, no sync_err.
- sys_rst_n pulse low mid-pixel -> all outputs 0 immediately; subsequent data bytes produce no pi_flag until a header arrives.
